// File: rtl/fb_arb_pkg.sv
// Shared types and the round-robin pick function for the framebuffer write arbiter.
// rr_pick works on a fixed 8-wide vector so any NREQ in 2..8 can use it zero-extended.
package fb_arb_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} arb_state_t;

   localparam int NREQ_MAX       = 8;
   localparam int MAX_BURST_DFLT = 16;
   localparam int BEAT_CNT_BITS  = $clog2(MAX_BURST_DFLT) + 1;

   // Search last+1, last+2, ... modulo n and return the first valid one-hot.
   function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                                   input logic [2:0]          last,
                                                   input int                  n);
      logic [NREQ_MAX-1:0] oh;
      int idx;
      oh = '0;
      for (int k = 1; k <= NREQ_MAX; k++) begin
         idx = int'(last) + k;
         if (idx >= n) idx = idx - n;
         if (k <= n && oh == '0 && valid[idx[2:0]]) oh[idx[2:0]] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester-side beat bus and framebuffer write port of the arbiter.
// master = requesters/pixel sink side, slave = the arbiter itself.
interface fb_write_arbiter_if #(
   parameter int NREQ         = 4,
   parameter int FB_ADDR_BITS = 20,
   parameter int DATA_W       = 24
);
   logic [NREQ-1:0]                   req_valid_i;
   logic [NREQ-1:0][FB_ADDR_BITS-1:0] req_addr_i;
   logic [NREQ-1:0][DATA_W-1:0]       req_data_i;
   logic [NREQ-1:0]                   req_last_i;
   logic [NREQ-1:0]                   req_ready_o;
   logic [FB_ADDR_BITS-1:0]           pxl_addr_o;
   logic [DATA_W-1:0]                 pxl_data_o;
   logic                              pxl_en_o;

   modport master (
      output req_valid_i, req_addr_i, req_data_i, req_last_i,
      input  req_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, req_last_i,
      output req_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o
   );
endinterface

// File: rtl/fb_write_arbiter_rr_priority_sel.sv
// Combinational rotate-then-priority select: first valid requester after the last owner,
// as one-hot, as an index, and an any-valid flag.
module rr_priority_sel
   import fb_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_valid,
   input  logic [IDX_W-1:0] i_last,
   output logic [NREQ-1:0]  o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [NREQ_MAX-1:0] w_oh;

   assign w_oh     = rr_pick(NREQ_MAX'(i_valid), 3'(i_last), NREQ);
   assign o_onehot = w_oh[NREQ-1:0];
   assign o_any    = |w_oh;

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < NREQ_MAX; i++) begin
         if (w_oh[i]) o_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing the framebuffer write port among NREQ writers.
// Out-of-range beats are accepted but never written, and raise a sticky error flag.
module fb_write_arbiter
   import fb_arb_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int FB_PIXELS    = 921600,
   parameter int FB_ADDR_BITS = 20,
   parameter int DATA_W       = 24,
   parameter int MAX_BURST    = 16
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            enable_i,
   fb_write_arbiter_if.slave bus,
   output logic [NREQ-1:0] grant_o,
   output logic            busy_o,
   output logic            err_o
);

   localparam int IDX_W  = $clog2(NREQ);
   localparam int CNT_REQ = $clog2(MAX_BURST) + 1;
   localparam int CNT_W  = (CNT_REQ > BEAT_CNT_BITS) ? CNT_REQ : BEAT_CNT_BITS;
   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_LOCK = LOCK;
   localparam logic [FB_ADDR_BITS:0] PIX_LIM = (FB_ADDR_BITS+1)'(FB_PIXELS);
   localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MAX_BURST);

   logic [0:0]              r_state;
   logic [NREQ-1:0]         r_grant;
   logic [IDX_W-1:0]        r_owner;
   logic [IDX_W-1:0]        r_last;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_pxl_en_p1;
   logic [FB_ADDR_BITS-1:0] r_pxl_addr_p1;
   logic [DATA_W-1:0]       r_pxl_data_p1;
   logic                    r_err;

   logic [NREQ-1:0]         w_sel_oh;
   logic [IDX_W-1:0]        w_sel_idx;
   logic                    w_any;
   logic                    w_own_valid;
   logic                    w_own_last;
   logic [FB_ADDR_BITS-1:0] w_own_addr;
   logic [DATA_W-1:0]       w_own_data;
   logic                    w_xfer;
   logic                    w_in_range;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic                    w_release;

   rr_priority_sel #(.NREQ(NREQ), .IDX_W(IDX_W)) u_sel (
      .i_valid  (bus.req_valid_i),
      .i_last   (r_last),
      .o_onehot (w_sel_oh),
      .o_idx    (w_sel_idx),
      .o_any    (w_any)
   );

   // p0: owner's beat and handshake, combinational from state/owner/enable
   assign w_own_valid = bus.req_valid_i[r_owner];
   assign w_own_last  = bus.req_last_i[r_owner];
   assign w_own_addr  = bus.req_addr_i[r_owner];
   assign w_own_data  = bus.req_data_i[r_owner];

   assign bus.req_ready_o = (r_state == ST_LOCK && enable_i) ? r_grant : '0;
   assign w_xfer      = (r_state == ST_LOCK) && enable_i && w_own_valid;
   assign w_cnt_nxt   = r_cnt + CNT_W'(1);
   // No transfer (owner idle or gate closed) also releases, so a stalled owner never starves others.
   assign w_release   = !w_xfer || w_own_last || (w_cnt_nxt == CNT_MAX);
   assign w_in_range  = {1'b0, w_own_addr} < PIX_LIM;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_owner <= '0;
         r_last  <= IDX_W'(NREQ - 1);
         r_cnt   <= '0;
      end else if (r_state == ST_IDLE) begin
         if (enable_i && w_any) begin
            r_state <= ST_LOCK;
            r_grant <= w_sel_oh;
            r_owner <= w_sel_idx;
            r_cnt   <= '0;
         end
      end else begin
         if (w_xfer) r_cnt <= w_cnt_nxt;
         if (w_release) begin
            r_state <= ST_IDLE;
            r_last  <= r_owner;
            r_grant <= '0;
         end
      end
   end

   // p1: registered write port
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_pxl_en_p1   <= 1'b0;
         r_pxl_addr_p1 <= '0;
         r_pxl_data_p1 <= '0;
         r_err         <= 1'b0;
      end else begin
         r_pxl_en_p1 <= w_xfer && w_in_range;
         if (w_xfer && w_in_range) begin
            r_pxl_addr_p1 <= w_own_addr;
            r_pxl_data_p1 <= w_own_data;
         end
         if (w_xfer && !w_in_range) r_err <= 1'b1;
      end
   end

   assign bus.pxl_en_o   = r_pxl_en_p1;
   assign bus.pxl_addr_o = r_pxl_addr_p1;
   assign bus.pxl_data_o = r_pxl_data_p1;
   assign grant_o        = r_grant;
   assign busy_o         = (r_state == ST_LOCK);
   assign err_o          = r_err;

endmodule
